branch_predict: RTL and testbench

BRANCH_PREDICT -- requirements
Module: branch_predict

---
 rtl/branch_predict.sv | 168 ++++++++++++++++
 tb/tb_branch_predict.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict.sv
// ============================================================================
// branch_predict
// ----------------------------------------------------------------------------
// Purpose
//    Direction predictor for a classic five-stage pipeline. A table of 2-bit
//    saturating counters (the PHT) is read combinationally in decode to give a
//    taken / not-taken prediction. It is trained in execute once the branch
//    outcome is known.
//
//    Build option (macro BP_GSHARE_EN):
//       undefined (default) - bimodal predictor. The PHT is indexed by PC
//                             bits only and no history registers exist.
//       defined             - gshare predictor. The PC index is XORed with a
//                             global history register. Decode uses a
//                             speculative history and execute uses an
//                             architectural history. The speculative copy is
//                             repaired from the architectural one on a
//                             mispredict.
//
// Parameters
//    PHT_AW : PHT index width, 2**PHT_AW counters
//    GHR_W  : global history width (GHR_W <= PHT_AW), gshare build only
//
// Ports
//    clk          in   single clock, rising edge
//    rst          in   asynchronous active-high reset
//    stallD       in   decode stage held
//    flushD       in   decode instruction squashed
//    branchD      in   decode instruction is a conditional branch
//    pcD[31:0]    in   decode instruction PC
//    pred_takeD   out  predicted direction for the decode branch
//    stallE       in   execute stage held
//    branchE      in   execute instruction is a conditional branch
//    pcE[31:0]    in   execute instruction PC
//    branch_takeE in   resolved direction from the execute comparator
//    pred_takeE   in   prediction carried down the pipe with the branch
//    mispredictE  out  execute branch was mispredicted (front-end flush)
// ============================================================================
module branch_predict #(
   parameter int PHT_AW = 6,
   parameter int GHR_W  = PHT_AW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        branchD,
   input  logic [31:0] pcD,
   output logic        pred_takeD,
   input  logic        stallE,
   input  logic        branchE,
   input  logic [31:0] pcE,
   input  logic        branch_takeE,
   input  logic        pred_takeE,
   output logic        mispredictE
);

   localparam int PHT_N = 1 << PHT_AW;

   // Pattern history table of 2-bit saturating counters
   logic [1:0]        r_pht [PHT_N];

   logic [PHT_AW-1:0] w_pcIdxD;
   logic [PHT_AW-1:0] w_pcIdxE;
   logic [PHT_AW-1:0] w_idxD;
   logic [PHT_AW-1:0] w_idxE;
   logic              w_commitE;
   logic              w_predTakeD;
   logic [1:0]        w_ctrE;
   logic [1:0]        w_ctrNext;

   // Word-aligned PCs: bits [1:0] never differ between branches, and the
   // upper bits beyond the index are deliberately aliased.
   logic              w_unusedPcBits;
   assign w_unusedPcBits = ^{pcD[31:PHT_AW+2], pcD[1:0],
                             pcE[31:PHT_AW+2], pcE[1:0]};

   assign w_pcIdxD = pcD[PHT_AW+1:2];
   assign w_pcIdxE = pcE[PHT_AW+1:2];

   // A held execute stage keeps presenting the same branch, so training is
   // gated on the cycle it actually leaves E. This gives exactly one update
   // per branch.
   assign w_commitE = branchE & ~stallE;

   // The mispredict flag must be visible for as long as the branch sits in E,
   // so it is deliberately not gated by stallE.
   assign mispredictE = branchE & (pred_takeE ^ branch_takeE);

`ifdef BP_GSHARE_EN
   // Speculative history: shifted by every decode prediction.
   // Architectural history: shifted only by resolved, committed branches.
   logic [GHR_W-1:0] r_ghrSpec;
   logic [GHR_W-1:0] r_ghrArch;
   logic [GHR_W-1:0] w_ghrArchNext;
   logic [GHR_W-1:0] w_ghrSpecNext;

   // Zero-extend each history to the index width before hashing.
   // idxE uses the history from before this branch's own shift.
   assign w_idxD = w_pcIdxD ^ PHT_AW'(r_ghrSpec);
   assign w_idxE = w_pcIdxE ^ PHT_AW'(r_ghrArch);

   // Shift-left-by-one, inserting the newest outcome at bit 0. The size cast
   // drops the oldest bit.
   assign w_ghrArchNext = GHR_W'({r_ghrArch, branch_takeE});
   assign w_ghrSpecNext = GHR_W'({r_ghrSpec, w_predTakeD});

   // History maintenance. A committed mispredict rebuilds the speculative
   // history from the corrected architectural one. This wins over any decode
   // shift in the same cycle, because that decode instruction is on the
   // wrong path and is about to be flushed. Flushed or stalled decode
   // branches leave the history alone, so that a branch shifts it only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ghrSpec <= '0;
         r_ghrArch <= '0;
      end else begin
         if (w_commitE) begin
            r_ghrArch <= w_ghrArchNext;
         end
         if (w_commitE && mispredictE) begin
            r_ghrSpec <= w_ghrArchNext;
         end else if (branchD && !stallD && !flushD) begin
            r_ghrSpec <= w_ghrSpecNext;
         end
      end
   end
`else
   // Bimodal: the PC bits alone select the counter
   assign w_idxD = w_pcIdxD;
   assign w_idxE = w_pcIdxE;
`endif

   // Predict from the counter MSB. The read sees the table before any
   // same-cycle training write, so a branch that is both predicted and
   // trained in one cycle uses the old counter.
   assign w_predTakeD = branchD & r_pht[w_idxD][1];
   assign pred_takeD  = w_predTakeD;

   // Saturating increment or decrement of the counter being trained
   assign w_ctrE = r_pht[w_idxE];

   always_comb begin
      w_ctrNext = w_ctrE;
      if (branch_takeE) begin
         if (w_ctrE != 2'b11) begin
            w_ctrNext = w_ctrE + 2'b01;
         end
      end else begin
         if (w_ctrE != 2'b00) begin
            w_ctrNext = w_ctrE - 2'b01;
         end
      end
   end

   // Counter table. On reset every entry becomes weakly not-taken. After
   // that, only the entry of the committing execute branch is written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_N; i++) begin
            r_pht[i] <= 2'b01;
         end
      end else if (w_commitE) begin
         r_pht[w_idxE] <= w_ctrNext;
      end
   end

endmodule

// File: tb/tb_branch_predict.sv
// ============================================================================
// tb_branch_predict
// ----------------------------------------------------------------------------
// Scoreboard bench for branch_predict.
//
// The stimulus process drives one vector per cycle. Whenever a branch is
// present (branchD or branchE) it queues the hand-computed pred_takeD and
// mispredictE values for that cycle. The monitor pops an entry on every
// falling edge where a branch is present and compares it against the DUT.
//
// PC indices with the default PHT_AW = 6:
//    0x00400000 -> 0
//    0x00400010 -> 4
//    0x00400014 -> 5
//    0x00400018 -> 6
//    0x0040001C -> 7
//    0x00400020 -> 8
// ============================================================================
module tb_branch_predict;

   localparam logic [31:0] P0 = 32'h0040_0000;
   localparam logic [31:0] P4 = 32'h0040_0010;
   localparam logic [31:0] P5 = 32'h0040_0014;
   localparam logic [31:0] P6 = 32'h0040_0018;
   localparam logic [31:0] P7 = 32'h0040_001C;
   localparam logic [31:0] P8 = 32'h0040_0020;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallD, flushD, branchD;
   logic [31:0] pcD;
   logic        pred_takeD;
   logic        stallE, branchE, branch_takeE, pred_takeE;
   logic [31:0] pcE;
   logic        mispredictE;

   typedef struct {
      logic  expPred;
      logic  expMisp;
      string name;
   } expT;

   expT expQ[$];
   expT monEntry;
   int  errorCount = 0;
   int  checkCount = 0;

   always #5 clk = ~clk;

   branch_predict dut (
      .clk          (clk),
      .rst          (rst),
      .stallD       (stallD),
      .flushD       (flushD),
      .branchD      (branchD),
      .pcD          (pcD),
      .pred_takeD   (pred_takeD),
      .stallE       (stallE),
      .branchE      (branchE),
      .pcE          (pcE),
      .branch_takeE (branch_takeE),
      .pred_takeE   (pred_takeE),
      .mispredictE  (mispredictE)
   );

   // Drive one cycle's worth of inputs just after the rising edge, and queue
   // the expected outputs if a branch is present in either stage.
   task automatic applyStimulus(input string name,
                                input logic bD, input logic [31:0] pD,
                                input logic stD, input logic flD,
                                input logic bE, input logic [31:0] pE,
                                input logic stE, input logic tkE,
                                input logic prE,
                                input logic expPred, input logic expMisp);
      expT e;
      @(posedge clk);
      #1;
      branchD      = bD;
      pcD          = pD;
      stallD       = stD;
      flushD       = flD;
      branchE      = bE;
      pcE          = pE;
      stallE       = stE;
      branch_takeE = tkE;
      pred_takeE   = prE;
      if (bD || bE) begin
         e.expPred = expPred;
         e.expMisp = expMisp;
         e.name    = name;
         expQ.push_back(e);
      end
   endtask

   // Change reset away from the clock edge, with idle inputs
   task automatic setReset(input logic val);
      @(posedge clk);
      #1;
      rst     = val;
      branchD = 1'b0;
      branchE = 1'b0;
   endtask

   task automatic checkOutput(input string name, input logic act,
                              input logic exp);
      checkCount++;
      if (act !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   // Monitor: consume one expectation per cycle in which a branch is present
   always @(negedge clk) begin
      if (branchD || branchE) begin
         if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpected_branch: got branch with empty queue, expected none");
         end else begin
            monEntry = expQ.pop_front();
            checkOutput({monEntry.name, "_pred"}, pred_takeD, monEntry.expPred);
            checkOutput({monEntry.name, "_misp"}, mispredictE, monEntry.expMisp);
         end
      end
   end

   initial begin
      rst          = 1'b0;
      stallD       = 1'b0;
      flushD       = 1'b0;
      branchD      = 1'b0;
      pcD          = '0;
      stallE       = 1'b0;
      branchE      = 1'b0;
      pcE          = '0;
      branch_takeE = 1'b0;
      pred_takeE   = 1'b0;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);

      // In reset: prediction is 0, mispredict is still combinational, and
      // the attempted commit must not train anything
      applyStimulus("rst_hold", 1, P4, 0, 0, 1, P4, 0, 0, 1, 0, 1);
      setReset(1'b0);

`ifdef BP_GSHARE_EN
      // Train counter[4] to 10 with no mispredict. ghr_arch becomes 000001.
      applyStimulus("g_train4",   0, P0, 0, 0, 1, P4, 0, 1, 1, 0, 0);
      // A flushed decode branch predicts but must not shift ghr_spec
      applyStimulus("g_flushD",   1, P4, 0, 1, 0, P0, 0, 0, 0, 1, 0);
      // A stalled decode branch, held for 3 cycles, must not shift
      applyStimulus("g_stallD1",  1, P4, 1, 0, 0, P0, 0, 0, 0, 1, 0);
      applyStimulus("g_stallD2",  1, P4, 1, 0, 0, P0, 0, 0, 0, 1, 0);
      applyStimulus("g_stallD3",  1, P4, 1, 0, 0, P0, 0, 0, 0, 1, 0);
      // Released: one shift of pred=1, so ghr_spec becomes 000001
      applyStimulus("g_release",  1, P4, 0, 0, 0, P0, 0, 0, 0, 1, 0);
      // pc idx5 ^ 000001 = 4, so predict from counter 10 (held, no shift)
      applyStimulus("g_hist1",    1, P5, 1, 0, 0, P0, 0, 0, 0, 1, 0);
      // Decode would shift to 000011. The mispredicting commit (idxE = 0^1)
      // forces ghr_spec = ghr_arch = 000010 instead.
      applyStimulus("g_misp",     1, P5, 0, 0, 1, P0, 0, 0, 1, 1, 1);
      // idx6 ^ 000010 = 4 gives 1. Commit trains idx 6^2 = 4, giving 11.
      applyStimulus("g_repair",   1, P6, 1, 0, 1, P6, 0, 1, 1, 1, 0);
      // idx7 ^ 000010 = 5, still 01
      applyStimulus("g_idx5",     1, P7, 1, 0, 0, P0, 0, 0, 0, 0, 0);
      applyStimulus("g_idx4",     1, P6, 1, 0, 0, P0, 0, 0, 0, 1, 0);
`else
      // Fresh counters are weakly not-taken
      applyStimulus("bm_init4",   1, P4, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      applyStimulus("bm_init0",   1, P0, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      // Same-index predict and train: old value this cycle (01 -> 10)
      applyStimulus("bm_inc1",    1, P4, 0, 0, 1, P4, 0, 1, 0, 0, 1);
      applyStimulus("bm_inc2",    1, P4, 0, 0, 1, P4, 0, 1, 1, 1, 0);
      applyStimulus("bm_inc3",    1, P4, 0, 0, 1, P4, 0, 1, 1, 1, 0);
      // Saturated at 11: decrements go 11 -> 10 -> 01 -> 00 -> 00
      applyStimulus("bm_dec1",    1, P4, 0, 0, 1, P4, 0, 0, 1, 1, 1);
      applyStimulus("bm_dec2",    1, P4, 0, 0, 1, P4, 0, 0, 1, 1, 1);
      applyStimulus("bm_dec3",    1, P4, 0, 0, 1, P4, 0, 0, 0, 0, 0);
      applyStimulus("bm_dec4",    1, P4, 0, 0, 1, P4, 0, 0, 0, 0, 0);
      // Saturated at 00: 00 -> 01 -> 10
      applyStimulus("bm_up1",     1, P4, 0, 0, 1, P4, 0, 1, 0, 0, 1);
      applyStimulus("bm_up2",     1, P4, 0, 0, 1, P4, 0, 1, 0, 0, 1);
      applyStimulus("bm_up3",     1, P4, 0, 0, 0, P0, 0, 0, 0, 1, 0);
      // Held execute branch: mispredict every cycle, one training update
      applyStimulus("bm_stE1",    1, P8, 1, 0, 1, P8, 1, 1, 0, 0, 1);
      applyStimulus("bm_stE2",    1, P8, 1, 0, 1, P8, 1, 1, 0, 0, 1);
      applyStimulus("bm_stE3",    1, P8, 0, 0, 1, P8, 0, 1, 0, 0, 1);
      applyStimulus("bm_stE4",    1, P8, 0, 0, 0, P0, 0, 0, 0, 1, 0);
      applyStimulus("bm_stE5",    1, P8, 0, 0, 1, P8, 0, 0, 1, 1, 1);
      applyStimulus("bm_stE6",    1, P8, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      // No E branch means no mispredict, even though pred and take differ
      applyStimulus("bm_noE",     1, P0, 0, 0, 0, P0, 0, 0, 1, 0, 0);
      // No D branch means no prediction, even though counter[4] is 10
      applyStimulus("bm_noD",     0, P4, 0, 0, 1, P0, 1, 1, 1, 0, 0);
`endif

      // Reset in the middle of operation restores weakly not-taken state
      setReset(1'b1);
      applyStimulus("mid_rst",    1, P4, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      setReset(1'b0);
      applyStimulus("post_rst4",  1, P4, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      applyStimulus("post_rst6",  1, P6, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      applyStimulus("idle",       0, P0, 0, 0, 0, P0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);

      checkCount++;
      if (expQ.size() != 0) begin
         errorCount++;
         $display("[TB] FAIL queue_drain: got %0d pending, expected 0", expQ.size());
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
